// File: rtl/ifu_dynbpu.sv
// ifu_dynbpu: decode-stage predictor with 2-bit BHT; return-address stack built when E203_BPU_RAS_EN is defined
module ifu_dynbpu #(
  parameter int PC_SIZE   = 32,
  parameter int BHT_DEPTH = 64,
  parameter int RAS_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_SIZE-1:0] pc,
  input  logic               dec_i_valid,
  input  logic               dec_jal,
  input  logic               dec_jalr,
  input  logic               dec_bxx,
  input  logic               dec_rvc,
  input  logic [PC_SIZE-1:0] dec_bjp_imm,
  input  logic               dec_rd_link,
  input  logic               dec_rs1_link,
  input  logic               dec_rs1_x0,
  input  logic [PC_SIZE-1:0] rf2bpu_x1,
  input  logic               x1_dep,
  input  logic               upd_valid,
  input  logic [PC_SIZE-1:0] upd_pc,
  input  logic               upd_taken,
  input  logic               upd_flush,
  output logic               prdt_taken,
  output logic [PC_SIZE-1:0] prdt_pc,
  output logic               bpu_wait
);
  localparam int IW = $clog2(BHT_DEPTH);
  logic [1:0] bht_q [BHT_DEPTH];
  logic [IW-1:0] pidx, uidx;
  logic [1:0] ucnt, ucnt_d;
  logic ret, x1_known, jalr_known, known, unused;
  logic [PC_SIZE-1:0] ras_top, op1, sum, tgt, link;
  assign pidx = pc[IW:1];
  assign uidx = upd_pc[IW:1];
  assign ucnt = bht_q[uidx];
  assign ucnt_d = upd_taken ? ((ucnt == 2'b11) ? ucnt : ucnt + 2'd1)
                            : ((ucnt == 2'b00) ? ucnt : ucnt - 2'd1);
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
    else if (upd_valid) bht_q[uidx] <= ucnt_d;
  assign ret = dec_jalr & dec_rs1_link;
  assign link = pc + (dec_rvc ? PC_SIZE'(2) : PC_SIZE'(4));
  assign jalr_known = dec_rs1_x0 | (dec_rs1_link & x1_known);
  assign op1 = dec_jalr ? (dec_rs1_x0 ? '0 : ras_top) : pc;
  assign sum = op1 + dec_bjp_imm;
  assign tgt = dec_jalr ? {sum[PC_SIZE-1:1], 1'b0} : sum;
  assign known = dec_jal | dec_bxx | (dec_jalr & jalr_known);
  // Outputs fall back to the fetch PC whenever no target can be produced
  assign prdt_taken = dec_i_valid & (dec_jal | (dec_bxx & bht_q[pidx][1]) | (dec_jalr & jalr_known));
  assign prdt_pc = (dec_i_valid & known) ? tgt : pc;
`ifdef E203_BPU_RAS_EN
  localparam int RW = $clog2(RAS_DEPTH);
  localparam logic [RW:0] RFULL = (RW+1)'(RAS_DEPTH);
  logic [PC_SIZE-1:0] ras_q [RAS_DEPTH];
  logic [RW-1:0] ptr_q, top;
  logic [RW:0] cnt_q;
  logic fire, push, pop;
  assign top = ptr_q - RW'(1);
  assign ras_top = ras_q[top];
  assign x1_known = cnt_q != '0;
  assign bpu_wait = 1'b0;
  assign fire = dec_i_valid & ~bpu_wait;
  assign push = fire & (dec_jal | dec_jalr) & dec_rd_link;
  assign pop = fire & ret & ~dec_rd_link & x1_known;
  // A link-to-link jalr on a non-empty stack swaps the top in place
  always_ff @(posedge clk)
    if (rst | upd_flush) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push & ret & x1_known) ras_q[top] <= link;
    else if (push) begin
      ras_q[ptr_q] <= link;
      ptr_q <= ptr_q + RW'(1);
      cnt_q <= (cnt_q == RFULL) ? cnt_q : cnt_q + (RW+1)'(1);
    end else if (pop) begin
      ptr_q <= top;
      cnt_q <= cnt_q - (RW+1)'(1);
    end
  assign unused = ^{rf2bpu_x1, x1_dep, upd_pc};
`else
  assign ras_top = rf2bpu_x1;
  assign x1_known = 1'b1;
  assign bpu_wait = dec_i_valid & ret & x1_dep;
  assign unused = ^{dec_rvc, dec_rd_link, upd_flush, link, upd_pc};
`endif
endmodule
